// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encodings and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake bundle; SERIAL_ADDER_OVF_EN adds the signed-overflow flag
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+cin, LSB first, one full-adder cell; optional ovf via SERIAL_ADDER_OVF_EN
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_q, s_full;
  logic [WIDTH-2:0] s_sr_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q, s, c, last, accept;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
  assign bus.ovf = ovf_q;
`endif
  serial_fa_cell u_fa (.a(a_sr_q[0]), .b(b_sr_q[0]), .ci(carry_q), .s(s), .co(c));
  assign last     = cnt_q == CW'(WIDTH - 1);
  assign accept   = state_q == ST_IDLE && bus.start;
  assign s_full   = {s, s_sr_q};
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  // next state: IDLE -> RUN on start, RUN -> DONE after the last bit, DONE -> IDLE unconditionally
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = bus.start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = last ? ST_DONE : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end
  // state, operand shifters, carry, counter and result registers; result loads only on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= state_q == ST_RUN;
      done_q  <= state_q == ST_DONE;
      if (accept) begin
        a_sr_q  <= bus.a;
        b_sr_q  <= bus.b;
        carry_q <= bus.cin;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        a_sr_q  <= a_sr_q >> 1;
        b_sr_q  <= b_sr_q >> 1;
        s_sr_q  <= s_full[WIDTH-1:1];
        carry_q <= c;
        cnt_q   <= last ? cnt_q : cnt_q + CW'(1);
        if (last) begin
          sum_q  <= s_full;
          cout_q <= c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_q  <= carry_q ^ c;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=4), ovf checked when SERIAL_ADDER_OVF_EN is defined
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [3:0] last_sum = 4'd0;
  logic last_cout = 1'b0;
  serial_adder_if #(.WIDTH(4)) bus ();
  serial_adder #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_, input logic tc, input logic noise,
                       input logic [3:0] es, input logic ec, input logic eo);
    int n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_; bus.cin = tc;
    @(negedge clk);
    if (noise) begin
      bus.a = 4'd1; bus.b = 4'd1; bus.cin = 1'b0;
    end else begin
      bus.start = 1'b0; bus.a = 4'($urandom); bus.b = 4'($urandom); bus.cin = 1'($urandom);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) bus.start = 1'b0;
      check($sformatf("busy k=%0d", k), 32'(bus.busy), 32'(k <= 4));
      check($sformatf("done k=%0d", k), 32'(bus.done), 32'(k == 5));
      if (bus.done) n_done++;
      if (k == 2) begin
        check("sum held", 32'(bus.sum), 32'(last_sum));
        check("cout held", 32'(bus.cout), 32'(last_cout));
      end
      if (k == 5) begin
        check($sformatf("sum %0d+%0d+%0d", ta, tb_, tc), 32'(bus.sum), 32'(es));
        check($sformatf("cout %0d+%0d+%0d", ta, tb_, tc), 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check($sformatf("ovf %0d+%0d+%0d", ta, tb_, tc), 32'(bus.ovf), 32'(eo));
`endif
      end
    end
    check("done pulses", 32'(n_done), 32'd1);
    last_sum = es;
    last_cout = ec;
  endtask
  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst sum", 32'(bus.sum), 32'd0);
    check("rst cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle busy", 32'(bus.busy), 32'd0);
      check("idle done", 32'(bus.done), 32'd0);
    end
    check("idle sum", 32'(bus.sum), 32'd0);
    check("idle cout", 32'(bus.cout), 32'd0);
    do_op(4'd7, 4'd3, 1'b0, 1'b0, 4'd10, 1'b0, 1'b1);
    do_op(4'd15, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    do_op(4'd7, 4'd3, 1'b1, 1'b0, 4'd11, 1'b0, 1'b1);
    do_op(4'd7, 4'd3, 1'b0, 1'b1, 4'd10, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no restart busy", 32'(bus.busy), 32'd0);
      check("no second done", 32'(bus.done), 32'd0);
    end
    check("result kept", 32'(bus.sum), 32'd10);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd15; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort sum", 32'(bus.sum), 32'd0);
    check("abort cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort no done", 32'(bus.done), 32'd0);
    end
    last_sum = 4'd0;
    last_cout = 1'b0;
    do_op(4'd5, 4'd6, 1'b0, 1'b0, 4'd11, 1'b0, 1'b1);
    do_op(4'd7, 4'd1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1);
    do_op(4'd15, 4'd15, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
